data_memory_bank: RTL and testbench
===================================

# data_memory_bank

Parametrised, byte-addressable data memory for the MEM stage of the 5-stage pipeline. It supports byte, half-word and word loads and stores, with sign or zero extension on loads. Read data is registered, with a one-cycle valid strobe. Misaligned and out-of-range accesses are flagged instead of corrupting memory. After reset it sweeps all words to zero and holds `busy` so hazard logic can stall the pipeline.

## Interface
Parameters:
- `DEPTH`, 16: number of 32-bit words; any value ≥ 2, not required to be a power of two.
- `CLEAR_ON_RESET`, 1: 1 = zero every word after reset; 0 = skip the clear and leave contents unchanged.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `addr`  in  32  byte address from the ALU result.
- `wdata`  in  32  store data; the low bytes are used for sb/sh.
- `mem_read`  in  1  load request this cycle.
- `mem_write`  in  1  store request this cycle.
- `size`  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `load_unsigned`  in  1  1 = zero-extend loads; 0 = sign-extend.
- `rdata`  out  32  registered, extended load data.
- `rdata_valid`  out  1  one-cycle pulse, one cycle after an accepted load.
- `busy`  out  1  high while the clear sweep runs; requests are ignored.
- `err_misaligned`  out  1  one-cycle pulse for a misaligned or illegal-size access.
- `err_range`  out  1  one-cycle pulse for a word index ≥ `DEPTH`.

## Operation
- **State machine:** two states, CLEAR and READY.
  - While `rst` = 1: the next state is CLEAR if `CLEAR_ON_RESET` = 1, otherwise READY.
  - In CLEAR: `clr_ptr` is zeroed; each cycle, word `clr_ptr` is written with 0 and `clr_ptr` increments. The transition to READY happens in the cycle that clears word `DEPTH-1`.
  - READY loops to itself.
- **Reset values:** `rdata` = 0, `rdata_valid` = 0, `err_misaligned` = 0, `err_range` = 0, `busy` = 1 if `CLEAR_ON_RESET` = 1, else 0.
- **Reset mid-sweep:** the sweep restarts from word 0.
- **Requests in CLEAR:** ignored entirely; no strobes and no errors are produced.
- **Address decode:**
  - Word index = `addr[31:2]`.
  - Byte lane = `addr[1:0]`.
  - The range check compares the full 30-bit index against `DEPTH`; upper bits are never truncated and aliased.
- **Misaligned cases:**
  - Half-word with `addr[0]` = 1.
  - Word with `addr[1:0]` ≠ 0.
  - `size` = 11.
  - When both misalignment and out-of-range apply, both error flags pulse.
- **Stores (READY, `mem_write` = 1, no error):**
  - Byte: writes `wdata[7:0]` into the selected lane.
  - Half: writes `wdata[15:0]` into lanes {1,0} or {3,2}, selected by `addr[1]`.
  - Word: writes all four lanes.
  - Unselected lanes keep their contents.
  - A store with an error writes nothing.
- **Loads (READY, `mem_read` = 1):**
  - Next cycle: `rdata_valid` = 1.
  - If there is no error, `rdata` = the selected byte or half, extended according to `load_unsigned`; for word size, the full word.
  - If there is an error, `rdata` = 0 and the error flag pulses in the same cycle as `rdata_valid`, so the pipeline never hangs.
- **`rdata` hold:** `rdata` holds its value until the next accepted load.
- **Simultaneous `mem_read` and `mem_write`, same or different address:**
  - Both are performed.
  - The load returns the pre-store contents (read-before-write).
  - Errors are evaluated once, on the shared address and size.
- **Error timing for stores:** error pulses for store-only accesses appear one cycle after the request.

## Timing
- Load latency is 1 cycle, from the request edge to `rdata`/`rdata_valid`; accepted loads can be issued back to back every cycle.
- A store is visible to a load issued in the following cycle.
- Clear sweep:
  - The sweep takes exactly `DEPTH` cycles after the first edge with `rst` = 0.
  - `busy` falls after the edge that writes word `DEPTH-1`.
  - The first request can be accepted in the cycle after that edge.
- `busy` is a registered output that depends only on the state, so the hazard unit can use it as a stall without combinational paths from the request inputs.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- **Reset and clear sweep:**
  - Stimulus: `DEPTH` = 16; hold `rst` for 2 cycles, then release.
  - Response: `busy` = 1 for exactly 16 cycles, then 0. A word load from address 0x3C then returns 0x00000000 with `rdata_valid` one cycle later.
- **Byte/half stores with extension:**
  - Stimulus:
    - Word store of 0x11223344 to address 0x8.
    - Byte store of 0x80 to address 0x9.
    - Half store of 0xFFFE to address 0xA.
  - Response:
    - Word load from 0x8 returns 0xFFFE8044.
    - Signed byte load from 0x9 returns 0xFFFFFF80.
    - Unsigned half load from 0xA returns 0x0000FFFE.
- **Misaligned and range errors:**
  - Word store to address 0x6: `err_misaligned` pulses once and memory is unchanged.
  - Word load from address 4×`DEPTH`: `err_range` pulses, `rdata` = 0 and `rdata_valid` = 1.
  - `size` = 11: `err_misaligned` pulses.
- **Read-before-write:**
  - Stimulus: word 0x4 holds 0xAAAA5555; in the same cycle, `mem_read` = 1 and `mem_write` = 1 with `wdata` = 0x12345678.
  - Response: `rdata` = 0xAAAA5555; the next load returns 0x12345678.
- **Requests during busy and reset mid-sweep:**
  - Stimulus: a store of 0xDEADBEEF to address 0x0 at sweep cycle 3; then `rst` asserted at sweep cycle 8.
  - Response:
    - The store is ignored and no strobes are produced.
    - The sweep restarts and `busy` stays high for 16 more cycles.
    - Word 0 reads 0.
- **`CLEAR_ON_RESET` = 0:** `busy` = 0 immediately after reset. A word store of 0xCAFEF00D to address 0x0 followed by a load returns 0xCAFEF00D with 1-cycle latency.

Source files
------------

// File: rtl/data_memory_bank.sv
// Byte-addressable data memory for the MEM stage: registered loads with sign/zero
// extension, lane-masked stores, error strobes and a post-reset clear sweep.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_CLEAR | zeroing one word per cycle at clr_ptr_q; busy, requests ignored
//   S_READY | normal load/store service
module data_memory_bank #(
    parameter int DEPTH          = 16,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        busy,
    output logic        err_misaligned,
    output logic        err_range
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    typedef enum logic {
        S_READY = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam state_t RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_READY;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
    logic            clear_we;

    logic [31:0]     mem_q [DEPTH];

    logic            ready;
    logic            out_of_range;
    logic            misaligned;
    logic            any_err;
    logic            ld_acc;
    logic            st_acc;
    logic [AW-1:0]   widx;
    logic [31:0]     rd_word;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [31:0]     ld_data;
    logic [3:0]      st_be;
    logic [31:0]     st_data;

    logic [31:0]     rdata_q;
    logic            rdata_valid_q;
    logic            err_mis_q;
    logic            err_rng_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RST_STATE;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        clear_we  = 1'b0;
        case (state_q)
            S_CLEAR: begin
                clear_we  = !rst;
                clr_ptr_d = clr_ptr_q + AW'(1);
                if (clr_ptr_q == AW'(DEPTH - 1)) begin
                    state_d   = S_READY;
                    clr_ptr_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Full 30-bit index is compared so high address bits never alias into the array.
    assign ready        = (state_q == S_READY) && !rst;
    assign out_of_range = ({2'b00, addr[31:2]} >= DEPTH_U);
    assign widx         = addr[AW+1:2];

    always_comb begin
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    assign any_err = misaligned || out_of_range;
    assign ld_acc  = ready && mem_read;
    assign st_acc  = ready && mem_write && !any_err;

    assign rd_word  = mem_q[widx];
    assign byte_sel = rd_word[{addr[1:0], 3'b000} +: 8];
    assign half_sel = addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_data = rd_word;
        case (size)
            2'b00: ld_data = load_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01: ld_data = load_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: ;
        endcase
    end

    always_comb begin
        st_be   = 4'b1111;
        st_data = wdata;
        case (size)
            2'b00: begin
                st_be   = 4'b0001 << addr[1:0];
                st_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                st_be   = addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Read data is taken combinationally before this edge's store, giving read-before-write.
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem_q[clr_ptr_q] <= '0;
        end else if (st_acc) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) mem_q[widx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            err_mis_q     <= 1'b0;
            err_rng_q     <= 1'b0;
        end else begin
            rdata_valid_q <= ld_acc;
            err_mis_q     <= ready && (mem_read || mem_write) && misaligned;
            err_rng_q     <= ready && (mem_read || mem_write) && out_of_range;
            if (ld_acc) rdata_q <= any_err ? 32'h0 : ld_data;
        end
    end

    assign rdata          = rdata_q;
    assign rdata_valid    = rdata_valid_q;
    assign busy           = (state_q == S_CLEAR);
    assign err_misaligned = err_mis_q;
    assign err_range      = err_rng_q;

endmodule

// File: tb/tb_data_memory_bank.sv
// Bench for data_memory_bank: directed scenarios plus random traffic checked against
// a byte-array reference model; a second instance covers CLEAR_ON_RESET = 0.
module tb_data_memory_bank;

    localparam int DA = 16;
    localparam int DB = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_rd, a_wr, a_uns, a_valid, a_busy, a_mis, a_rng;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [1:0]  a_size;
    logic        b_rst, b_rd, b_wr, b_uns, b_valid, b_busy, b_mis, b_rng;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [1:0]  b_size;

    data_memory_bank #(.DEPTH(DA), .CLEAR_ON_RESET(1'b1)) u_dut_a (
        .clk(clk), .rst(a_rst), .addr(a_addr), .wdata(a_wdata),
        .mem_read(a_rd), .mem_write(a_wr), .size(a_size), .load_unsigned(a_uns),
        .rdata(a_rdata), .rdata_valid(a_valid), .busy(a_busy),
        .err_misaligned(a_mis), .err_range(a_rng)
    );

    data_memory_bank #(.DEPTH(DB), .CLEAR_ON_RESET(1'b0)) u_dut_b (
        .clk(clk), .rst(b_rst), .addr(b_addr), .wdata(b_wdata),
        .mem_read(b_rd), .mem_write(b_wr), .size(b_size), .load_unsigned(b_uns),
        .rdata(b_rdata), .rdata_valid(b_valid), .busy(b_busy),
        .err_misaligned(b_mis), .err_range(b_rng)
    );

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  mdl [4*DA];
    logic [31:0] exp_rdata = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request on instance A; expectation computed from the byte model before the edge.
    task automatic do_cycle(input logic rd, input logic wr, input logic [31:0] ad,
                            input logic [1:0] sz, input logic uns, input logic [31:0] wd);
        int         nb;
        int         base;
        logic       mis;
        logic       rng;
        logic [63:0] v;
        nb   = 1 << sz;
        mis  = (sz == 2'd3) || ((int'(ad[1:0]) % nb) != 0);
        rng  = ({2'b00, ad[31:2]} >= 32'(DA));
        base = rng ? 0 : int'(ad[31:2]) * 4 + int'(ad[1:0]);
        if (rd) begin
            if (mis || rng) begin
                exp_rdata = 32'h0;
            end else begin
                v = 64'h0;
                for (int b = 0; b < nb; b++) v = v | (64'(mdl[base+b]) << (8*b));
                if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
                exp_rdata = v[31:0];
            end
        end
        if (wr && !mis && !rng) begin
            for (int b = 0; b < nb; b++) mdl[base+b] = wd[8*b +: 8];
        end
        a_rd = rd; a_wr = wr; a_addr = ad; a_size = sz; a_uns = uns; a_wdata = wd;
        @(posedge clk); #1;
        chk("valid",   32'(a_valid), 32'(rd));
        chk("rdata",   a_rdata, exp_rdata);
        chk("err_mis", 32'(a_mis), 32'((rd || wr) && mis));
        chk("err_rng", 32'(a_rng), 32'((rd || wr) && rng));
        chk("busy",    32'(a_busy), 32'h0);
        a_rd = 1'b0; a_wr = 1'b0;
    endtask

    task automatic b_cycle(input logic rd, input logic wr, input logic [31:0] ad,
                           input logic [1:0] sz, input logic [31:0] wd);
        b_rd = rd; b_wr = wr; b_addr = ad; b_size = sz; b_uns = 1'b0; b_wdata = wd;
        @(posedge clk); #1;
        b_rd = 1'b0; b_wr = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        logic [31:0] ad;
        logic [1:0]  sz;

        a_rst = 1'b1; a_rd = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0; a_size = 2'd2; a_uns = 1'b0;
        b_rst = 1'b1; b_rd = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0; b_size = 2'd2; b_uns = 1'b0;
        for (int i = 0; i < 4*DA; i++) mdl[i] = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        chk("a_rst_busy",  32'(a_busy), 32'h1);
        chk("a_rst_rdata", a_rdata, 32'h0);
        chk("a_rst_strb",  {29'b0, a_valid, a_mis, a_rng}, 32'h0);
        chk("b_rst_busy",  32'(b_busy), 32'h0);
        chk("b_rst_rdata", b_rdata, 32'h0);

        // CLEAR_ON_RESET = 0 instance, DEPTH = 6 (not a power of two)
        b_rst = 1'b0;
        chk("b_busy_after", 32'(b_busy), 32'h0);
        b_cycle(1'b0, 1'b1, 32'h0, 2'd2, 32'hCAFEF00D);
        chk("b_st_strb", {29'b0, b_valid, b_mis, b_rng}, 32'h0);
        b_cycle(1'b1, 1'b0, 32'h0, 2'd2, 32'h0);
        chk("b_ld_valid", 32'(b_valid), 32'h1);
        chk("b_ld_data",  b_rdata, 32'hCAFEF00D);
        b_cycle(1'b0, 1'b0, 32'h0, 2'd2, 32'h0);
        chk("b_hold_valid", 32'(b_valid), 32'h0);
        chk("b_hold_data",  b_rdata, 32'hCAFEF00D);
        b_cycle(1'b0, 1'b1, 32'h14, 2'd2, 32'h01020304);
        b_cycle(1'b1, 1'b0, 32'h14, 2'd2, 32'h0);
        chk("b_last_word", b_rdata, 32'h01020304);
        chk("b_last_rng",  32'(b_rng), 32'h0);
        b_cycle(1'b1, 1'b0, 32'h18, 2'd2, 32'h0);
        chk("b_rng_flag",  {29'b0, b_valid, b_mis, b_rng}, 32'h5);
        chk("b_rng_data",  b_rdata, 32'h0);
        b_cycle(1'b1, 1'b0, 32'h8000_0000, 2'd2, 32'h0);
        chk("b_alias_rng", 32'(b_rng), 32'h1);
        chk("b_alias_dat", b_rdata, 32'h0);

        // Sweep interrupted by reset at cycle 8, with an ignored request at cycle 3
        a_rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                a_rd = 1'b1; a_wr = 1'b1; a_addr = 32'h0; a_size = 2'd2; a_wdata = 32'hDEADBEEF;
            end
            @(posedge clk); #1;
            a_rd = 1'b0; a_wr = 1'b0;
            chk("sweep1_busy", 32'(a_busy), 32'h1);
            chk("sweep1_strb", {29'b0, a_valid, a_mis, a_rng}, 32'h0);
        end
        a_rst = 1'b1;
        @(posedge clk); #1;
        a_rst = 1'b0;
        chk("restart_busy", 32'(a_busy), 32'h1);
        n = 0;
        while (a_busy && n < 40) begin
            if (n == 3) begin
                a_rd = 1'b1; a_wr = 1'b1; a_addr = 32'h0; a_size = 2'd2; a_wdata = 32'hDEADBEEF;
            end
            @(posedge clk); #1;
            a_rd = 1'b0; a_wr = 1'b0;
            n++;
            chk("sweep2_strb", {29'b0, a_valid, a_mis, a_rng}, 32'h0);
        end
        chk("sweep_len", 32'(n), 32'd16);

        do_cycle(1'b1, 1'b0, 32'h3C, 2'd2, 1'b0, 32'h0);
        chk("clr_last", a_rdata, 32'h0);
        do_cycle(1'b1, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0);
        chk("clr_word0", a_rdata, 32'h0);

        do_cycle(1'b0, 1'b1, 32'h8, 2'd2, 1'b0, 32'h11223344);
        do_cycle(1'b0, 1'b1, 32'h9, 2'd0, 1'b0, 32'h00000080);
        do_cycle(1'b0, 1'b1, 32'hA, 2'd1, 1'b0, 32'h0000FFFE);
        do_cycle(1'b1, 1'b0, 32'h8, 2'd2, 1'b0, 32'h0);
        chk("lw_merge", a_rdata, 32'hFFFE8044);
        do_cycle(1'b1, 1'b0, 32'h9, 2'd0, 1'b0, 32'h0);
        chk("lb_sext", a_rdata, 32'hFFFFFF80);
        do_cycle(1'b1, 1'b0, 32'hA, 2'd1, 1'b1, 32'h0);
        chk("lhu_zext", a_rdata, 32'h0000FFFE);

        do_cycle(1'b0, 1'b1, 32'h4, 2'd2, 1'b0, 32'hAAAA5555);
        do_cycle(1'b0, 1'b1, 32'h6, 2'd2, 1'b0, 32'hBBBBBBBB);
        do_cycle(1'b0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0);
        do_cycle(1'b1, 1'b0, 32'h4, 2'd2, 1'b0, 32'h0);
        chk("mis_nowrite", a_rdata, 32'hAAAA5555);
        do_cycle(1'b1, 1'b0, 32'(4*DA), 2'd2, 1'b0, 32'h0);
        chk("rng_zero", a_rdata, 32'h0);
        do_cycle(1'b1, 1'b0, 32'h0, 2'd3, 1'b0, 32'h0);
        do_cycle(1'b1, 1'b0, 32'h8000_0000, 2'd1, 1'b0, 32'h0);

        do_cycle(1'b1, 1'b1, 32'h4, 2'd2, 1'b0, 32'h12345678);
        chk("rbw_old", a_rdata, 32'hAAAA5555);
        do_cycle(1'b1, 1'b0, 32'h4, 2'd2, 1'b0, 32'h0);
        chk("rbw_new", a_rdata, 32'h12345678);

        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 9))
                0:       ad = $urandom();
                1:       ad = 32'h4000_0000 | 32'($urandom_range(0, 63));
                default: ad = 32'($urandom_range(0, 4*DA + 7));
            endcase
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ad, sz,
                     1'($urandom_range(0, 1)), $urandom());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
